// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, coordinate width and controller state type
// for the VGA sync controller slice.
package vga_pkg;

    // Coordinate width for x / y outputs.
    localparam int COORD_W = 10;

    // Default pixel-clock divider (100 MHz system clock -> 25 MHz pixel rate).
    localparam int DEF_DIV = 4;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default 640x480@60 vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Controller run state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/vga_pix_tick_gen.sv
// vga_pix_tick_gen: divides the system clock into a one-clk pixel-rate
// enable. The counter is held at zero whenever en is low.
module vga_pix_tick_gen
    import vga_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pix_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Next divider count: wrap at DIV-1, clear while disabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        div_cnt_d = div_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops are written with non-blocking assignments only; blocking here would race other flops.
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign pix_tick = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: single-clock VGA timing generator. Produces the pixel enable,
// registered hsync/vsync/video_on/x/y/frame_start, and grants the shared
// frame-buffer write port to the UART side only outside active video.
// Optional build macro VGA_HBLANK_WR_EN: also open the write window during
// horizontal blanking of active lines.
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               pix_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start,
    input  logic               wr_req,
    output logic               wr_gnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Coordinate-width boundaries used by the counters and decodes.
    localparam logic [COORD_W-1:0] X_ACT     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] X_SYNC_S  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] X_SYNC_E  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] X_HB_LAST = COORD_W'(H_TOT - 2);
    localparam logic [COORD_W-1:0] Y_ACT     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] Y_SYNC_S  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] Y_SYNC_E  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] Y_VB_LAST = COORD_W'(V_TOT - 2);

    state_e             state_q, state_d;
    logic               started_q, started_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic               frame_start_q, frame_start_d;
    logic               wr_gnt_q, wr_gnt_d;
    logic               run;
    logic               win_vblank;
    logic               win_hblank;

    assign run = (state_q == RUN);

    // Pixel enable only counts while running and still enabled.
    vga_pix_tick_gen #(
        .DIV (DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run & en),
        .pix_tick (pix_tick)
    );

    // Write window: vertical blanking up to the second-to-last line, so the
    // last blanking line lets the write path drain before video resumes.
    always_comb begin
        win_vblank = run && (y_q >= Y_ACT) && (y_q <= Y_VB_LAST);
`ifdef VGA_HBLANK_WR_EN
        win_hblank = run && (y_q < Y_ACT) && (x_q >= X_ACT) && (x_q <= X_HB_LAST);
`else
        win_hblank = 1'b0;
`endif
    end

    // Next state, coordinates, registered decodes and write grant.
    always_comb begin
        state_d       = en ? RUN : IDLE;
        started_d     = started_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        frame_start_d = 1'b0;

        if (!en) begin
            started_d  = 1'b0;
            x_d        = '0;
            y_d        = '0;
            hsync_d    = 1'b1;
            vsync_d    = 1'b1;
            video_on_d = 1'b0;
        end else if (pix_tick) begin
            if (!started_q) begin
                // First pixel after entering RUN presents (0,0).
                started_d     = 1'b1;
                x_d           = '0;
                y_d           = '0;
                frame_start_d = 1'b1;
            end else if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
            // Decodes are computed for the coordinates being presented next.
            hsync_d    = !((x_d >= X_SYNC_S) && (x_d <= X_SYNC_E));
            vsync_d    = !((y_d >= Y_SYNC_S) && (y_d <= Y_SYNC_E));
            video_on_d = (x_d < X_ACT) && (y_d < Y_ACT);
        end

        wr_gnt_d = en && wr_req && (win_vblank || win_hblank);
    end

    // Controller register bank; reset gives the IDLE output values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            started_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            wr_gnt_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            started_q     <= started_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            wr_gnt_q      <= wr_gnt_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign wr_gnt      = wr_gnt_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb_vga_sync_ctrl: scoreboard bench for vga_sync_ctrl with a reduced timing
// so whole frames fit in a short run. A reference model derives every output
// from the number of clocks spent in RUN using plain arithmetic.
module tb_vga_sync_ctrl;

    localparam int DIV = 3;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = DIV * HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_req;
    logic       pix_tick, hsync, vsync, video_on, frame_start, wr_gnt;
    logic [9:0] x, y;

    vga_sync_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pix_tick),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
        .frame_start(frame_start), .wr_req(wr_req), .wr_gnt(wr_gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tick, hs, vs, von, fs, gnt;
        int px, py;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n = clocks since entering RUN; pixel p is shown from n = (p+1)*DIV.
    bit m_act = 1'b0;
    int m_n   = 0;
    bit m_gnt = 1'b0;
    bit m_rst_pend = 1'b0;

    function automatic bit m_window(input bit act, input int n);
        int p, px, py;
        bit w;
        if (!act || n < DIV) return 1'b0;
        p  = n / DIV - 1;
        px = p % HT;
        py = (p / HT) % VT;
        w  = (py >= VA) && (py <= VT - 2);
`ifdef VGA_HBLANK_WR_EN
        w  = w || ((py < VA) && (px >= HA) && (px <= HT - 2));
`endif
        return w;
    endfunction

    function automatic exp_t m_outputs(input bit act, input int n, input bit gnt);
        exp_t e;
        int p;
        e.tick = act && (n % DIV == DIV - 1);
        e.gnt  = gnt;
        e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.fs = 1'b0; e.px = 0; e.py = 0;
        if (act && n >= DIV) begin
            p     = n / DIV - 1;
            e.px  = p % HT;
            e.py  = (p / HT) % VT;
            e.hs  = !(e.px >= HA + HF && e.px < HA + HF + HS);
            e.vs  = !(e.py >= VA + VF && e.py < VA + VF + VS);
            e.von = (e.px < HA) && (e.py < VA);
            e.fs  = (n % DIV == 0) && (p % (HT * VT) == 0);
        end
        return e;
    endfunction

    always @(negedge rst_n) m_rst_pend = 1'b1;

    initial begin
        forever begin
            bit new_gnt;
            @(posedge clk);
            if (m_rst_pend || !rst_n) begin
                m_act = 1'b0; m_n = 0; m_gnt = 1'b0;
                m_rst_pend = 1'b0;
            end
            if (rst_n) begin
                new_gnt = wr_req && en && m_window(m_act, m_n);
                if (en) begin
                    if (m_act) m_n++;
                    else begin m_act = 1'b1; m_n = 0; end
                end else begin
                    m_act = 1'b0; m_n = 0;
                end
                m_gnt = new_gnt;
            end
            exp_q.push_back(m_outputs(m_act, m_n, m_gnt));
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pix_tick", pix_tick, e.tick);
                check("hsync", hsync, e.hs);
                check("vsync", vsync, e.vs);
                check("video_on", video_on, e.von);
                check("x", x, e.px);
                check("y", y, e.py);
                check("frame_start", frame_start, e.fs);
                check("wr_gnt", wr_gnt, e.gnt);
                check("gnt_during_video", wr_gnt & video_on, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic measure_latency(input string name);
        int lat = 0;
        bit found = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin found = 1'b1; lat = k; end
        end
        check(name, lat, DIV + 1);
        check({name, "_x"}, x, 0);
        check({name, "_y"}, y, 0);
        check({name, "_video_on"}, video_on, 1'b1);
    endtask

    initial begin
        int  period;
        int  hs_low, vs_low, gnt_seen;
        bit  found;

        rst_n = 1'b0; en = 1'b0; wr_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_x", x, 0);
        check("reset_hsync", hsync, 1'b1);
        check("reset_vsync", vsync, 1'b1);
        check("reset_gnt", wr_gnt, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // en rising -> frame_start after DIV+1 clocks
        measure_latency("en_to_frame_start");

        // one frame with wr_req held: period and sync widths
        period = 0; hs_low = 0; vs_low = 0; gnt_seen = 0; found = 1'b0;
        for (int c = 1; c <= 2 * FRAME && !found; c++) begin
            @(negedge clk);
            wr_req = 1'b1;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (wr_gnt) gnt_seen++;
            @(posedge clk);
            #1;
            if (frame_start) begin found = 1'b1; period = c; end
        end
        check("frame_period", period, FRAME);
        check("hsync_low_clks", hs_low, HS * DIV * VT);
        check("vsync_low_clks", vs_low, VS * DIV * HT);
        check("grant_seen", gnt_seen > 0, 1'b1);

        // random write requests for another frame
        for (int c = 0; c < FRAME + 20; c++) begin
            @(negedge clk);
            wr_req = ($urandom_range(0, 3) != 0);
        end

        // drop en mid-frame
        found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(posedge clk);
            #1;
            if (y == 10'd4) found = 1'b1;
        end
        check("reach_y4", found, 1'b1);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("drop_hsync", hsync, 1'b1);
        check("drop_vsync", vsync, 1'b1);
        check("drop_video_on", video_on, 1'b0);
        check("drop_xy", {x, y}, 0);
        repeat (3) @(negedge clk);
        measure_latency("reen_to_frame_start");

        // random enable toggling
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 79) == 0) en = ~en;
            wr_req = $urandom_range(0, 1);
        end

        // async reset while granted
        @(negedge clk);
        en = 1'b1; wr_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3 * FRAME && !found; c++) begin
            @(posedge clk);
            #1;
            if (wr_gnt) found = 1'b1;
        end
        check("grant_before_reset", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", wr_gnt, 1'b0);
        check("async_rst_xy", {x, y}, 0);
        check("async_rst_tick", pix_tick, 1'b0);
        check("async_rst_hsync", hsync, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        en = 1'b0; wr_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_ctrl.md
# vga_sync_ctrl

Sequences the VGA display pipeline from the fast system clock. It derives a pixel-rate clock enable and generates hsync/vsync, active-video and pixel coordinates. It also arbitrates the single frame-buffer write port between display fetch and the UART writer, granting writes only outside active video. It sits between the system clock and the VGA pixel/RGB logic and replaces free-running divided clocks with a single-clock-domain enable.

## Interface
- DIV, 4: clk cycles per pixel (100 MHz -> 25 MHz); legal values >= 2.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low forces the idle state.
- pix_tick  out  1  one-clk pulse per pixel.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  current pixel is in the active area.
- x  out  10  current column, 0..H_TOTAL-1.
- y  out  10  current line, 0..V_TOTAL-1.
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented.
- wr_req  in  1  UART-side frame-buffer write request, level.
- wr_gnt  out  1  write port granted to the UART side, registered.

## Operation
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- States:
  - IDLE: entered on reset or when en=0.
  - RUN: entered from IDLE when en=1.
- Divider counter div_cnt runs 0..DIV-1 in RUN. pix_tick=1 while div_cnt==DIV-1.
- On the first pix_tick after entering RUN, the block loads x=0, y=0 and asserts frame_start.
- On each later pix_tick, x increments. At x==H_TOTAL-1, x wraps to 0 and y increments. At y==V_TOTAL-1, y wraps to 0 and frame_start pulses.
- Decodes, valid for the presented (x, y):
  - hsync=0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync=0 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - video_on = (x<H_ACTIVE) & (y<V_ACTIVE).
- IDLE outputs: div_cnt=0, x=0, y=0, hsync=1, vsync=1, video_on=0, pix_tick=0, frame_start=0, wr_gnt=0.
- en falling in mid-frame: the block is in IDLE on the next clk, and all outputs take the IDLE values.
- Write window = RUN & (V_ACTIVE <= y <= V_TOTAL-2). The last blanking line is excluded so the write path drains before active video.
- wr_gnt <= wr_req & window. The UART side may write on every clk that has wr_gnt=1. A write is complete only when the grant is seen.

## Timing
- x, y, hsync, vsync, video_on and frame_start are registered and change together, on the clk edge after the pix_tick cycle.
- Latency from en rising to frame_start = DIV+1 clks.
- wr_gnt rises 1 clk after wr_req rises inside the window. It falls 1 clk after wr_req falls, or 1 clk after the window closes.
- wr_gnt is never high while video_on=1.
- wr_req and window end on the same clk: the grant drops on the next clk, and no grant is issued once the window has closed.
- Reset asserted at any time: all outputs take the IDLE values immediately, without waiting for a clk edge.
- Frame period = DIV*H_TOTAL*V_TOTAL clks (1,680,000 at the defaults).

## Configuration
- VGA_HBLANK_WR_EN:
  - Defined: the window also includes horizontal blanking of active lines, i.e. y<V_ACTIVE and H_ACTIVE <= x <= H_TOTAL-2.
  - Undefined: only the vertical-blanking window applies.

## Structure
- Shared package vga_pkg holds:
  - the default timing constants and H_TOTAL/V_TOTAL;
  - the coordinate width (10);
  - the state enum {IDLE, RUN}.
- One sub-module, vga_pix_tick_gen: the DIV counter producing pix_tick, with en and rst_n inputs.
- Counters, decode and grant logic live in vga_sync_ctrl.

## Test plan
- Reset, then en=1 at defaults -> first pix_tick at clk 4; frame_start with x=0, y=0 at clk 5; video_on=1.
- Run one full line -> hsync low for exactly 96 pix_ticks starting at x=656; video_on low from x=640; x wraps 799->0 with y+1.
- Run one full frame -> vsync low for y=490..491; frame_start period = 1,680,000 clks.
- Hold wr_req=1 for a full frame -> wr_gnt high only while y is in 480..523 (plus, with VGA_HBLANK_WR_EN, x in 640..798 of lines 0..479); never coincident with video_on.
- Drop en at y=200 -> next clk: hsync=1, vsync=1, video_on=0, x=y=0. Re-raise en -> frame_start after DIV+1 clks.
- Assert rst_n=0 asynchronously with wr_gnt=1 -> wr_gnt=0 before the next clk edge.
